fp_argmin_stream: RTL and testbench
===================================

Name: fp_argmin_stream

Overview:
- Streaming FP32 nearest-match engine for the face-verification datapath.
- Accepts a burst of N IEEE-754 single-precision distance scores over a valid/ready stream.
- Tracks the minimum score and its index, then reports whether that minimum meets a programmable acceptance threshold.
- Uses the codebase's FP32 ordering convention (sign, then exponent, then mantissa), built as an internal registered compare stage.

Parameters:
- IDX_W, 10, width of sample count and index; max burst 2^IDX_W - 1.

Ports:
- clk  input  1  system clock
- rst  input  1  synchronous active-high reset
- start  input  1  one-cycle pulse; latches count and threshold, begins burst
- count  input  IDX_W  number of samples in burst
- threshold  input  32  FP32 acceptance threshold
- in_valid  input  1  sample valid
- in_ready  output  1  engine can accept sample
- in_data  input  32  FP32 sample
- busy  output  1  burst in progress
- done  output  1  one-cycle pulse; results valid
- min_value  output  32  smallest sample of last burst
- min_index  output  IDX_W  index (0-based) of smallest sample
- match  output  1  min_value <= threshold

Behaviour:
- One clock, all state on posedge clk. rst is synchronous and active-high.
- Reset values: in_ready=0, busy=0, done=0, min_value=32'h7F800000 (+inf), min_index=0, match=0. The state machine goes to IDLE.
- States:
  - IDLE: start=1 latches count and threshold and clears the running minimum to +inf, index 0.
    - If count=0: go to DONE.
    - Otherwise: go to RUN.
    - start is ignored in all other states.
  - RUN: in_ready=1 and busy=1.
    - A sample is accepted on a cycle with in_valid && in_ready.
    - The accepted sample is compared against the running minimum.
    - If the sample is strictly less, it replaces min_value, and min_index takes the current sample counter.
    - The sample counter increments on every accept.
    - When the accept being processed is sample count-1, go to DONE on the next edge. in_ready drops in DONE.
  - DONE: lasts exactly one cycle. done=1, busy=0, match is registered, then the FSM returns to IDLE.
- Latency: done asserts exactly one cycle after the final accepted sample. A back-to-back burst of N samples takes N+2 cycles from start to done.
- Ordering rule ("A less than B"):
  - Signs differ: the negative operand is less. -0 (0x80000000) is less than +0.
  - Signs equal and positive: the lower {exp,mant} is less.
  - Signs equal and negative: the higher {exp,mant} is less.
  - Equal bit patterns: not less. On ties the earlier index is retained.
- match = NOT(threshold less than min_value). It is evaluated on the final minimum, in DONE.
- count=0: done pulses two cycles after start. Results are +inf, index 0, match = (threshold is +inf or a larger pattern per the ordering rule).
- min_value, min_index and match hold their values after done until the next start or rst.
- in_valid outside RUN is ignored and has no side effects.
- rst during RUN: the burst is abandoned and all outputs return to reset values on the next edge. done is not pulsed.
- in_data is sampled only on accept cycles. No combinational path from in_valid to in_ready.

Optional Feature:
- Macro FP_ARGMIN_NAN_SKIP_EN.
- Defined:
  - Samples with exp=8'hFF and mant!=0 (NaN) are accepted and counted, but never update the minimum.
  - A sticky output nan_seen (1 bit) asserts if any NaN was accepted in the burst. It is cleared on start and rst, and valid at done.
- Undefined:
  - NaN samples are ordered purely by bit pattern per the ordering rule.
  - A positive NaN never wins against a finite sample; a negative NaN can win.
  - The nan_seen port does not exist.

Test Plan:
- count=4, threshold=0x3F000000 (0.5), samples 0x3F800000, 0x3E800000, 0x40000000, 0x3E800000 back-to-back -> done 6 cycles after start; min_value=0x3E800000, min_index=1 (tie keeps earlier), match=1.
- count=3, threshold=0x3F000000, samples 0x3F800000, 0x3FC00000, 0x40400000, with in_valid gaps of 2 cycles -> min_value=0x3F800000, index 0, match=0; done 1 cycle after third accept.
- count=2, samples 0x00000000, 0x80000000 -> min_value=0x80000000, index 1. Negative ordering check: samples 0xBF800000, 0xC0000000 -> min_value=0xC0000000, index 1.
- count=0, threshold=0x7F800000 -> done 2 cycles after start, min_value=0x7F800000, match=1. start pulsed while busy -> ignored, and the burst completes normally.
- rst asserted after 2 of 5 samples -> next edge: busy=0, in_ready=0, min_value=0x7F800000, no done. A new start runs a clean burst.
- With FP_ARGMIN_NAN_SKIP_EN, count=3, samples 0x7FC00000, 0x40000000, 0xFFC00000 -> min_value=0x40000000, index 1, nan_seen=1. Without the macro -> min_value=0xFFC00000, index 2.

Source files
------------

// File: rtl/fp_argmin_stream.sv
// ---------------------------------------------------------------------------
// fp_argmin_stream
//
// Purpose: streaming FP32 nearest-match engine. A burst of `count` FP32
// distance scores arrives over a valid/ready stream; the engine tracks the
// smallest score and its 0-based index, then reports whether that minimum
// is <= a programmable acceptance threshold.
//
// FP32 ordering: sign first (negative is smaller, -0 < +0), then {exp,mant}
// (ascending for positive, descending for negative). Equal patterns are not
// "less", so ties keep the earlier index.
//
// Optional feature macro: FP_ARGMIN_NAN_SKIP_EN
//   defined   : NaN samples are accepted and counted but never update the
//               minimum; sticky output nan_seen flags any accepted NaN.
//   undefined : NaNs are ordered by bit pattern like any other value and
//               the nan_seen port does not exist.
//
// Ports:
//   clk        system clock
//   rst        synchronous active-high reset
//   start      one-cycle pulse; latches count/threshold (ignored unless idle)
//   count      samples in the burst (0 allowed)
//   threshold  FP32 acceptance threshold
//   in_valid   sample valid
//   in_ready   engine can accept a sample (depends on state only)
//   in_data    FP32 sample
//   busy       burst in progress
//   done       one-cycle pulse; results valid
//   min_value  smallest sample of the last burst (+inf when empty)
//   min_index  index of the smallest sample
//   match      min_value <= threshold
//   nan_seen   (macro only) a NaN was accepted in the last burst
// ---------------------------------------------------------------------------
module fp_argmin_stream #(
  parameter int IDX_W = 10
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [IDX_W-1:0] count,
  input  logic [31:0]      threshold,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      in_data,
  output logic             busy,
  output logic             done,
  output logic [31:0]      min_value,
  output logic [IDX_W-1:0] min_index,
  output logic             match
`ifdef FP_ARGMIN_NAN_SKIP_EN
  ,
  output logic             nan_seen
`endif
);

  localparam logic [31:0] POS_INF = 32'h7F80_0000;

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

  state_t           state_q, state_d;
  logic [IDX_W-1:0] count_q, cnt_q, pipe_idx_q, min_idx_q, min_idx_d;
  logic [31:0]      thr_q, pipe_data_q, min_q, min_d;
  logic             pipe_vld_q, done_q, match_q;
  logic             start_go, accept, last_accept, sample_wins;

  // a strictly less than b under the sign / exponent / mantissa ordering
  function automatic logic fp_less(input logic [31:0] a, input logic [31:0] b);
    if (a[31] != b[31]) return a[31];
    else if (!a[31])    return a[30:0] < b[30:0];
    else                return a[30:0] > b[30:0];
  endfunction

  function automatic logic is_nan(input logic [31:0] v);
    return (v[30:23] == 8'hFF) && (v[22:0] != 23'd0);
  endfunction

  assign start_go    = (state_q == S_IDLE) && start;
  assign accept      = in_ready && in_valid;
  assign last_accept = accept && (cnt_q == count_q - IDX_W'(1));

  // ---- FSM: state register ----
  always_ff @(posedge clk) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  // ---- FSM: next state ----
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (start) state_d = (count == '0) ? S_DONE : S_RUN;
      S_RUN:   if (last_accept) state_d = S_DONE;
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // ---- FSM: outputs (state only, so no in_valid -> in_ready path) ----
  always_comb begin
    in_ready = 1'b0;
    busy     = 1'b0;
    if (state_q == S_RUN) begin
      in_ready = 1'b1;
      busy     = 1'b1;
    end
  end

  // Compare stage: the sample registered on the previous accept is compared
  // against the running minimum. The last sample is folded in during DONE,
  // so match uses min_d to see the final minimum.
`ifdef FP_ARGMIN_NAN_SKIP_EN
  assign sample_wins = pipe_vld_q && !is_nan(pipe_data_q) && fp_less(pipe_data_q, min_q);
`else
  assign sample_wins = pipe_vld_q && fp_less(pipe_data_q, min_q);
`endif

  always_comb begin
    min_d     = min_q;
    min_idx_d = min_idx_q;
    if (sample_wins) begin
      min_d     = pipe_data_q;
      min_idx_d = pipe_idx_q;
    end
  end

  // ---- datapath ----
  always_ff @(posedge clk) begin
    if (rst) begin
      count_q     <= '0;
      thr_q       <= '0;
      cnt_q       <= '0;
      pipe_vld_q  <= 1'b0;
      pipe_data_q <= '0;
      pipe_idx_q  <= '0;
      min_q       <= POS_INF;
      min_idx_q   <= '0;
      match_q     <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      pipe_vld_q <= accept;
      done_q     <= (state_q == S_DONE);
      if (accept) begin
        pipe_data_q <= in_data;
        pipe_idx_q  <= cnt_q;
        cnt_q       <= cnt_q + IDX_W'(1);
      end
      if (start_go) begin
        count_q   <= count;
        thr_q     <= threshold;
        cnt_q     <= '0;
        min_q     <= POS_INF;
        min_idx_q <= '0;
        match_q   <= 1'b0;
      end else begin
        min_q     <= min_d;
        min_idx_q <= min_idx_d;
        if (state_q == S_DONE) match_q <= !fp_less(thr_q, min_d);
      end
    end
  end

`ifdef FP_ARGMIN_NAN_SKIP_EN
  logic nan_q;
  always_ff @(posedge clk) begin
    if (rst || start_go)                 nan_q <= 1'b0;
    else if (accept && is_nan(in_data))  nan_q <= 1'b1;
  end
  assign nan_seen = nan_q;
`endif

  assign done      = done_q;
  assign min_value = min_q;
  assign min_index = min_idx_q;
  assign match     = match_q;

endmodule

// File: tb/tb_fp_argmin_stream.sv
// ---------------------------------------------------------------------------
// tb_fp_argmin_stream
//
// Directed and randomized bursts against fp_argmin_stream. Expected results
// come from a reference model that maps each FP32 pattern onto a monotone
// unsigned key and scans the burst for the first strict minimum.
// Build with +define+FP_ARGMIN_NAN_SKIP_EN to exercise the NaN-skip variant.
// ---------------------------------------------------------------------------
module tb_fp_argmin_stream;
  localparam int          IDX_W   = 10;
  localparam logic [31:0] POS_INF = 32'h7F80_0000;

  logic             clk = 1'b0;
  logic             rst, start, in_valid, in_ready, busy, done, match;
  logic [IDX_W-1:0] count, min_index;
  logic [31:0]      threshold, in_data, min_value;
`ifdef FP_ARGMIN_NAN_SKIP_EN
  logic             nan_seen;
`endif

  int n_cmp = 0;
  int n_bad = 0;
  int cyc   = 0;

  logic [31:0] smp[$];
  logic [31:0] got_min;
  int          got_idx;
  logic        got_match;
  logic        got_nan;

  fp_argmin_stream #(.IDX_W(IDX_W)) dut (
    .clk(clk), .rst(rst), .start(start), .count(count), .threshold(threshold),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .busy(busy),
    .done(done), .min_value(min_value), .min_index(min_index), .match(match)
`ifdef FP_ARGMIN_NAN_SKIP_EN
    , .nan_seen(nan_seen)
`endif
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Monotone key: unsigned key order equals the FP32 ordering rule.
  function automatic logic [31:0] fkey(input logic [31:0] v);
    return v[31] ? ~v : (v | 32'h8000_0000);
  endfunction

  function automatic bit fnan(input logic [31:0] v);
    return (v[30:23] == 8'hFF) && (v[22:0] != 0);
  endfunction

  function automatic logic [31:0] rand_sample(input logic [31:0] prev, input bit have_prev);
    logic [31:0] v;
    case ($urandom_range(0, 7))
      0: v = $urandom;
      1: v = have_prev ? prev : 32'h3F80_0000;
      2: v = 32'h0000_0000;
      3: v = 32'h8000_0000;
      4: v = {$urandom_range(0, 1) == 1, 31'h7F80_0000};
      5: v = {$urandom_range(0, 1) == 1, 8'hFF, 23'($urandom_range(1, 23'h7FFFFF))};
      default: v = {$urandom_range(0, 1) == 1, 8'($urandom_range(120, 134)), 23'($urandom)};
    endcase
    return v;
  endfunction

  // Runs one burst of n samples from smp. gap<0: random 0..2 idle cycles
  // between samples, else fixed. poke: pulse start mid-burst (must be ignored).
  // Called #1 after a posedge with the DUT idle.
  task automatic run_burst(input int n, input logic [31:0] thr, input int gap, input bit poke);
    logic [31:0] em;
    int          ei, s_cyc, l_cyc, w, g;
    bit          acc, en;
    logic        emt;
    em = POS_INF; ei = 0; en = 0;
    for (int i = 0; i < n; i++) begin
      if (fnan(smp[i])) en = 1;
`ifdef FP_ARGMIN_NAN_SKIP_EN
      if (!fnan(smp[i]) && fkey(smp[i]) < fkey(em)) begin em = smp[i]; ei = i; end
`else
      if (fkey(smp[i]) < fkey(em)) begin em = smp[i]; ei = i; end
`endif
    end
    emt = fkey(em) <= fkey(thr);

    start = 1'b1; count = IDX_W'(n); threshold = thr;
    @(posedge clk); #1;
    start = 1'b0;
    s_cyc = cyc;
    l_cyc = s_cyc;
    if (n > 0) begin
      chk("busy_in_run", 32'(busy), 32'd1);
      chk("ready_in_run", 32'(in_ready), 32'd1);
    end
    for (int i = 0; i < n; i++) begin
      g = (gap < 0) ? $urandom_range(0, 2) : gap;
      repeat (g) begin
        in_valid = 1'b0; in_data = $urandom;
        @(posedge clk); #1;
      end
      in_valid = 1'b1; in_data = smp[i];
      if (poke && i == 1) begin start = 1'b1; count = IDX_W'(1); threshold = 32'h0; end
      w = 0;
      forever begin
        acc = in_ready;
        @(posedge clk); #1;
        start = 1'b0;
        if (acc) break;
        w++;
        if (w > 20) begin chk("accept_timeout", 32'(w), 32'd0); break; end
      end
      l_cyc = cyc;
    end
    in_valid = 1'b0;
    w = 0;
    while (!done && w < 20) begin @(posedge clk); #1; w++; end
    chk("done_seen", 32'(done), 32'd1);
    chk("done_after_last", 32'(cyc), 32'(l_cyc + 1));
    if (gap == 0) chk("done_from_start", 32'(cyc), 32'(s_cyc + n + 1));
    chk("busy_at_done", 32'(busy), 32'd0);
    chk("min_value", min_value, em);
    chk("min_index", 32'(min_index), 32'(ei));
    chk("match", 32'(match), 32'(emt));
    got_min = min_value; got_idx = int'(min_index); got_match = match; got_nan = 1'b0;
`ifdef FP_ARGMIN_NAN_SKIP_EN
    chk("nan_seen", 32'(nan_seen), 32'(en));
    got_nan = nan_seen;
`endif
    @(posedge clk); #1;
    chk("done_one_cycle", 32'(done), 32'd0);
    chk("min_hold", min_value, em);
    $display("burst n=%0d thr=%h -> min=%h idx=%0d match=%0b nan=%0b (model %h/%0d/%0b)",
             n, thr, got_min, got_idx, got_match, got_nan, em, ei, emt);
  endtask

  initial begin
    logic [31:0] thr;
    int          n, w;
    bit          saw_done;

    rst = 1'b1; start = 1'b0; count = '0; threshold = '0; in_valid = 1'b0; in_data = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_in_ready", 32'(in_ready), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_min_value", min_value, POS_INF);
    chk("rst_min_index", 32'(min_index), 32'd0);
    chk("rst_match", 32'(match), 32'd0);
    rst = 1'b0;
    // in_valid while idle must have no effect
    in_valid = 1'b1; in_data = 32'hBF80_0000;
    @(posedge clk); #1;
    in_valid = 1'b0;
    chk("idle_valid_ignored", min_value, POS_INF);

    // tie keeps earlier index
    smp = '{32'h3F80_0000, 32'h3E80_0000, 32'h4000_0000, 32'h3E80_0000};
    run_burst(4, 32'h3F00_0000, 0, 0);
    chk("t1_min", got_min, 32'h3E80_0000);
    chk("t1_idx", 32'(got_idx), 32'd1);
    chk("t1_match", 32'(got_match), 32'd1);

    // gaps of 2 cycles
    smp = '{32'h3F80_0000, 32'h3FC0_0000, 32'h4040_0000};
    run_burst(3, 32'h3F00_0000, 2, 0);
    chk("t2_min", got_min, 32'h3F80_0000);
    chk("t2_idx", 32'(got_idx), 32'd0);
    chk("t2_match", 32'(got_match), 32'd0);

    // -0 below +0; negative ordering
    smp = '{32'h0000_0000, 32'h8000_0000};
    run_burst(2, 32'h0000_0000, 0, 0);
    chk("t3_min", got_min, 32'h8000_0000);
    chk("t3_idx", 32'(got_idx), 32'd1);
    smp = '{32'hBF80_0000, 32'hC000_0000};
    run_burst(2, 32'h0000_0000, 0, 0);
    chk("t3n_min", got_min, 32'hC000_0000);
    chk("t3n_idx", 32'(got_idx), 32'd1);

    // empty burst
    run_burst(0, POS_INF, 0, 0);
    chk("t4_min", got_min, POS_INF);
    chk("t4_match", 32'(got_match), 32'd1);

    // start while busy is ignored
    smp = '{32'h3F80_0000, 32'h3E80_0000, 32'h4000_0000, 32'h3E80_0000};
    run_burst(4, 32'h3F00_0000, 0, 1);
    chk("t4b_min", got_min, 32'h3E80_0000);
    chk("t4b_idx", 32'(got_idx), 32'd1);

    // reset mid-burst
    start = 1'b1; count = IDX_W'(5); threshold = 32'h3F00_0000;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (2) begin
      in_valid = 1'b1; in_data = 32'h3E00_0000;
      @(posedge clk); #1;
    end
    in_valid = 1'b0; rst = 1'b1;
    @(posedge clk); #1;
    chk("mid_rst_busy", 32'(busy), 32'd0);
    chk("mid_rst_ready", 32'(in_ready), 32'd0);
    chk("mid_rst_min", min_value, POS_INF);
    chk("mid_rst_idx", 32'(min_index), 32'd0);
    chk("mid_rst_done", 32'(done), 32'd0);
    rst = 1'b0;
    saw_done = 0;
    for (w = 0; w < 5; w++) begin
      @(posedge clk); #1;
      if (done) saw_done = 1;
    end
    chk("mid_rst_no_done", 32'(saw_done), 32'd0);
    smp = '{32'h4000_0000, 32'h3F80_0000, 32'h4040_0000};
    run_burst(3, 32'h3F80_0000, 0, 0);
    chk("post_rst_min", got_min, 32'h3F80_0000);
    chk("post_rst_idx", 32'(got_idx), 32'd1);
    chk("post_rst_match", 32'(got_match), 32'd1);

    // NaN handling
    smp = '{32'h7FC0_0000, 32'h4000_0000, 32'hFFC0_0000};
    run_burst(3, 32'h3F00_0000, 0, 0);
`ifdef FP_ARGMIN_NAN_SKIP_EN
    chk("nan_min", got_min, 32'h4000_0000);
    chk("nan_idx", 32'(got_idx), 32'd1);
    chk("nan_flag", 32'(got_nan), 32'd1);
`else
    chk("nan_min", got_min, 32'hFFC0_0000);
    chk("nan_idx", 32'(got_idx), 32'd2);
`endif

    // randomized bursts
    for (int b = 0; b < 12; b++) begin
      n = $urandom_range(1, 12);
      smp = {};
      for (int i = 0; i < n; i++)
        smp.push_back(rand_sample((i > 0) ? smp[i-1] : 32'h0, i > 0));
      thr = ($urandom_range(0, 1) == 1) ? smp[$urandom_range(0, n - 1)] : rand_sample(32'h0, 0);
      run_burst(n, thr, (b % 3 == 0) ? 0 : -1, 0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
